// File: rtl/stego_pkg.sv
// Shared defaults and state encoding for the steganography LSB datapath.
package stego_pkg;

  localparam int DEF_BPS        = 16;
  localparam int DEF_FRAME_SIZE = 8;
  localparam int DEF_MAX_LSB    = 4;
  localparam int NLSB_W         = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    EMBED = 1'b1
  } state_e;

  // Zero means one LSB; anything above max_lsb saturates.
  function automatic logic [NLSB_W-1:0] clamp_nlsb(input logic [NLSB_W-1:0] n,
                                                   input int unsigned max_lsb);
    if (n == '0) return NLSB_W'(1);
    if (32'(n) > max_lsb) return NLSB_W'(max_lsb);
    return n;
  endfunction

endpackage

// File: rtl/lsb_insert.sv
// Replaces the enabled low bits of one sample with message bits.
module lsb_insert
  import stego_pkg::*;
#(
  parameter int BPS     = DEF_BPS,
  parameter int MAX_LSB = DEF_MAX_LSB
) (
  input  logic [BPS-1:0]     sample_i,
  input  logic [NLSB_W-1:0]  nlsb_i,
  input  logic [MAX_LSB-1:0] bits_i,
  input  logic [MAX_LSB-1:0] mask_i,
  output logic [BPS-1:0]     sample_o
);

  always_comb begin
    sample_o = sample_i;
    for (int unsigned b = 0; b < MAX_LSB; b++) begin
      if (mask_i[b] && (b < 32'(nlsb_i))) sample_o[b] = bits_i[b];
    end
  end

endmodule

// File: rtl/lsb_embed_stream.sv
// Streaming LSB embedder: buffers message words and writes them into the
// low bits of each accepted audio frame until the message length is spent.
module lsb_embed_stream
  import stego_pkg::*;
#(
  parameter int BPS        = DEF_BPS,
  parameter int FRAME_SIZE = DEF_FRAME_SIZE,
  parameter int MAX_LSB    = DEF_MAX_LSB,
  parameter int MSG_W      = 32,
  parameter int LEN_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NLSB_W-1:0]          cfg_nlsb,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic [MSG_W-1:0]           msg_word,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [FRAME_SIZE*BPS-1:0]  in_frame,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FRAME_SIZE*BPS-1:0]  out_frame,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int BUF_W = FRAME_SIZE * MAX_LSB + MSG_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int FW    = FRAME_SIZE * BPS;

  state_e              state_q, state_d;
  logic [NLSB_W-1:0]   nlsb_q, nlsb_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [BUF_W-1:0]    buf_q, buf_d, buf_c;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_c;
  logic [FW-1:0]       out_frame_q, out_frame_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;

  logic [LEN_W-1:0]    k, need;
  logic                need_met, accept, fire, append;
  logic [FW-1:0]       frame_mod;

  assign k        = LEN_W'(FRAME_SIZE) * LEN_W'(nlsb_q);
  assign need     = (k < rem_q) ? k : rem_q;
  assign need_met = 32'(cnt_q) >= 32'(need);

  assign in_ready  = (!out_valid_q || out_ready) && ((state_q == IDLE) || need_met);
  assign msg_ready = (state_q == EMBED) && (32'(cnt_q) + 32'(MSG_W) <= 32'(BUF_W));
  assign accept    = in_valid && in_ready;
  assign fire      = accept && (state_q == EMBED);
  assign append    = msg_valid && msg_ready;

  // Message bit j lands in sample j/nlsb, bit j%nlsb, so sample s reads
  // its bits starting at buffer offset s*nlsb.
  for (genvar s = 0; s < FRAME_SIZE; s++) begin : g_smp
    logic [31:0]        base;
    logic [MAX_LSB-1:0] bits;
    logic [MAX_LSB-1:0] mask;

    assign base = 32'(s) * 32'(nlsb_q);
    assign bits = MAX_LSB'(buf_q >> base);

    always_comb begin
      mask = '0;
      for (int unsigned b = 0; b < MAX_LSB; b++) begin
        mask[b] = (state_q == EMBED) && (base + b < 32'(need));
      end
    end

    lsb_insert #(.BPS(BPS), .MAX_LSB(MAX_LSB)) u_ins (
      .sample_i (in_frame[s*BPS +: BPS]),
      .nlsb_i   (nlsb_q),
      .bits_i   (bits),
      .mask_i   (mask),
      .sample_o (frame_mod[s*BPS +: BPS])
    );
  end

  always_comb begin
    state_d     = state_q;
    nlsb_d      = nlsb_q;
    rem_d       = rem_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    buf_c       = buf_q;
    cnt_c       = cnt_q;
    done_d      = 1'b0;
    out_frame_d = out_frame_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          nlsb_d = clamp_nlsb(cfg_nlsb, MAX_LSB);
          if (msg_len != '0) begin
            state_d = EMBED;
            rem_d   = msg_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMBED: begin
        // Consume first, then append the new word above what is left.
        if (fire) begin
          buf_c = buf_q >> need;
          cnt_c = cnt_q - CNT_W'(need);
          rem_d = rem_q - need;
        end
        if (append) begin
          buf_c = buf_c | (BUF_W'(msg_word) << cnt_c);
          cnt_c = cnt_c + CNT_W'(MSG_W);
        end
        buf_d = buf_c;
        cnt_d = cnt_c;
        if (fire && (need == rem_q)) begin
          state_d = IDLE;
          buf_d   = '0;
          cnt_d   = '0;
          rem_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_frame_d = frame_mod;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nlsb_q      <= '0;
      rem_q       <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      out_frame_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nlsb_q      <= nlsb_d;
      rem_q       <= rem_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      out_frame_q <= out_frame_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out_frame = out_frame_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == EMBED);
  assign done      = done_q;

endmodule

// File: doc/lsb_embed_stream.md
Name: lsb_embed_stream

Overview:
- Streaming successor to the combinational per-frame LSB replacer in the steganography datapath.
- Accepts audio frames and a message word stream over valid/ready handshakes.
- Replaces a runtime-selectable number of LSBs per sample (1..MAX_LSB) with message bits and tracks the total message length.
- Passes frames through unmodified once the message is exhausted or when idle; sits between the sample framer and the output serializer.

Parameters:
- BPS, 16, bits per sample.
- FRAME_SIZE, 8, samples per frame.
- MAX_LSB, 4, max LSBs replaced per sample (1..BPS-1).
- MSG_W, 32, message input word width.
- LEN_W, 16, width of message length in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_nlsb and msg_len (honoured in IDLE only).
- cfg_nlsb  in  3  LSBs per sample to replace.
- msg_len  in  LEN_W  total message bits to embed.
- msg_word  in  MSG_W  message data, bit 0 embedded first.
- msg_valid  in  1  msg_word valid.
- msg_ready  out  1  buffer can accept msg_word.
- in_frame  in  FRAME_SIZE*BPS  sample k at bits [k*BPS +: BPS].
- in_valid  in  1  in_frame valid.
- in_ready  out  1  frame accepted when in_valid&&in_ready.
- out_frame  out  FRAME_SIZE*BPS  processed frame (registered).
- out_valid  out  1  out_frame valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  state==EMBED.
- done  out  1  one-cycle pulse when last message bit has been embedded.

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_frame=0, out_valid=0, msg_ready=0, busy=0, done=0, bit buffer count=0, remaining=0.
- nlsb clamp at start: 0 becomes 1; values above MAX_LSB become MAX_LSB. K = FRAME_SIZE*nlsb.
- Bit buffer: BUF_W = FRAME_SIZE*MAX_LSB + MSG_W bits, count register.
  - msg_ready = EMBED && (count + MSG_W <= BUF_W).
  - A word is appended above the existing count.
  - Consumed bits shift out from bit 0.
- IDLE:
  - Frames pass through unchanged.
  - msg_ready=0.
  - start with msg_len>0 moves to EMBED and loads remaining=msg_len.
  - start with msg_len==0 stays IDLE and pulses done next cycle.
- EMBED:
  - need = min(K, remaining). A frame is accepted only when count >= need.
  - Bit j of the consumed bits replaces bit (j % nlsb) of sample (j / nlsb). Samples/bits beyond need are unchanged.
  - remaining -= need, count -= need.
  - When remaining reaches 0: done pulses on the acceptance cycle+1, state returns to IDLE, and the buffer is flushed (count=0). Surplus bits of the final word are discarded.
- start during EMBED is ignored.
- Handshake:
  - in_ready = (!out_valid || out_ready) && (IDLE || count >= need).
  - Output register loads on acceptance; latency is 1 cycle.
  - out_frame and out_valid stay stable while out_valid && !out_ready.
  - No bubbles under full throughput.
- Simultaneous msg word append and frame consume in one cycle: count_next = count + MSG_W - need.
- Reset mid-EMBED aborts immediately, with no done pulse.

Decomposition:
- Shared package stego_pkg holds the default BPS, FRAME_SIZE and MAX_LSB, the state encoding (IDLE, EMBED), and the nlsb width constant.
- One sub-module: lsb_insert. It is combinational: one sample, nlsb, up to MAX_LSB bits plus a per-bit enable mask in, modified sample out. It is instantiated FRAME_SIZE times.

Test Plan:
- Idle passthrough: no start, frame of all 0xFFFF -> out_frame identical one cycle later, done=0, msg_ready=0.
- nlsb=1, msg_len=8, word 0x000000A5, samples all 0x1234 -> samples 0..7 = 1235,1234,1235,1234,1234,1235,1234,1235. done pulses; next frame unchanged; busy=0.
- nlsb=2, msg_len=20, words 0xFFFFFFFF, samples 0x0000 -> frame1 all 0x0003; frame2 samples0-1 0x0003, samples2-7 0x0000; done after frame2.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_frame stable, in_ready=0, no frame lost or duplicated; resumes in order.
- Starvation and clamp:
  - nlsb=4, msg_len=64, msg_valid delayed 10 cycles -> in_ready=0 until the word arrives.
  - Each accepted frame consumes 32 bits; samples get the low nibble from the message.
  - cfg_nlsb=0 behaves as 1.
- Reset mid-EMBED after one frame -> all outputs 0, IDLE. A new start with msg_len=8 embeds correctly from message bit 0.
